// File: rtl/abc_dq_pipe_pkg.sv
// Shared sign-magnitude fixed-point definitions for the abc->dq pipeline.
// Holds the default word geometry, the 1/sqrt(3) constant generator and the
// sign-magnitude negate/add/fit helpers used by the pipeline stages.
// Values are carried in a wide internal form (sign + SM_W-bit magnitude) so a
// single set of helpers serves any N up to 32 bits.
package abc_dq_pipe_pkg;

    localparam int unsigned DEF_N = 24;
    localparam int unsigned DEF_Q = 12;
    localparam int unsigned SM_W  = 64;

    typedef struct packed {
        logic            sign;
        logic [SM_W-1:0] mag;
    } sm_t;

    // round(2^q / sqrt(3)): integer square root of 2^(2q)/3, then round to nearest.
    function automatic logic [SM_W-1:0] inv_sqrt3(input int unsigned q);
        logic [SM_W-1:0] x;
        logic [SM_W-1:0] t;
        logic [SM_W-1:0] lim;
        logic [SM_W-1:0] odd;
        x   = '0;
        lim = SM_W'(1) << (2 * q);
        for (int bi = 31; bi >= 0; bi--) begin
            t = x | (SM_W'(1) << bi);
            if (t <= (SM_W'(1) << q)) begin
                if (SM_W'(3) * t * t <= lim) begin
                    x = t;
                end
            end
        end
        // x + 0.5 still below the root -> round up
        odd = SM_W'(2) * x + SM_W'(1);
        if (SM_W'(3) * odd * odd <= (lim << 2)) begin
            x = x + SM_W'(1);
        end
        return x;
    endfunction

    function automatic logic [SM_W-1:0] one(input int unsigned q);
        return SM_W'(1) << q;
    endfunction

    function automatic logic [SM_W-1:0] mag_max(input int unsigned n);
        return (SM_W'(1) << (n - 1)) - SM_W'(1);
    endfunction

    function automatic sm_t sm_neg(input sm_t x);
        sm_t r;
        r.mag  = x.mag;
        r.sign = (x.mag != '0) ? ~x.sign : 1'b0;
        return r;
    endfunction

    // Equal signs add magnitudes; otherwise larger minus smaller, sign of larger.
    function automatic sm_t sm_add(input sm_t x, input sm_t y);
        sm_t r;
        if (x.sign == y.sign) begin
            r.mag  = x.mag + y.mag;
            r.sign = x.sign;
        end else if (x.mag >= y.mag) begin
            r.mag  = x.mag - y.mag;
            r.sign = x.sign;
        end else begin
            r.mag  = y.mag - x.mag;
            r.sign = y.sign;
        end
        if (r.mag == '0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

    function automatic logic sm_ovf(input sm_t x, input int unsigned n);
        return x.mag > mag_max(n);
    endfunction

    // Clamp (sat) or truncate (wrap) a wide value into an n-bit word's magnitude range.
    function automatic sm_t sm_fit(input sm_t x, input int unsigned n, input bit sat);
        sm_t r;
        r = x;
        if (sm_ovf(x, n)) begin
            r.mag = sat ? mag_max(n) : (x.mag & mag_max(n));
        end
        if (r.mag == '0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_qmul_sat.sv
// Combinational sign-magnitude Q-format multiply with round-half-up and
// saturate/wrap on overflow.
// Ports: x, y - N-bit sign-magnitude operands
//        p    - N-bit sign-magnitude product
//        ovf  - product magnitude did not fit in N-1 bits
module sm_qmul_sat
    import abc_dq_pipe_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned Q      = DEF_Q,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] p,
    output logic         ovf
);

    localparam int unsigned PW = 2 * N;

    logic [PW-1:0]  prod;
    logic [PW-1:0]  rnd;
    logic [PW-1:0]  shifted;
    logic [N-2:0]   mag;
    logic           sign;

    always_comb begin
        prod    = PW'(x[N-2:0]) * PW'(y[N-2:0]);
        rnd     = prod + (PW'(1) << (Q - 1));
        shifted = rnd >> Q;
        ovf     = |(shifted >> (N - 1));
        if (ovf && SAT_EN) begin
            mag = '1;
        end else begin
            mag = shifted[N-2:0];
        end
        sign = (x[N-1] ^ y[N-1]) && (mag != '0);
        p    = {sign, mag};
    end

endmodule

// File: rtl/abc_dq_pipe.sv
// Four-stage pipelined Clarke+Park transform on sign-magnitude Q-format words:
//   d = A*cos + (B-C)/sqrt3*sin ; q = (B-C)/sqrt3*cos - A*sin
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready, a, b, c, cos_q, sin_q - input sample handshake
//        out_valid/out_ready, d, q, out_ovf       - output result handshake
//        ovf_sticky/ovf_clr                       - latched overflow indicator
// The whole pipe advances as one unit whenever the output register is free.
module abc_dq_pipe
    import abc_dq_pipe_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned Q      = DEF_Q,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] cos_q,
    input  logic [N-1:0] sin_q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         out_ovf,
    output logic         ovf_sticky,
    input  logic         ovf_clr
);

    localparam logic [SM_W-1:0] INV_FULL  = inv_sqrt3(Q);
    localparam logic [N-1:0]    INV_SQRT3 = {1'b0, INV_FULL[N-2:0]};

    function automatic sm_t widen(input logic [N-1:0] w);
        sm_t r;
        r.sign = w[N-1];
        r.mag  = SM_W'(w[N-2:0]);
        return r;
    endfunction

    function automatic logic [N-1:0] narrow(input sm_t x);
        return {x.sign, x.mag[N-2:0]};
    endfunction

    logic         advance;
    logic         v1_q, v2_q, v3_q, out_valid_q;
    logic [N-1:0] a1_q, cos1_q, sin1_q, s1_q;
    logic [N-1:0] k2_q, alpha2_q, cos2_q, sin2_q;
    logic [N-1:0] p1_q, p2_q, p3_q, p4_q;
    logic [N-1:0] d_q, q_q;
    logic         ovf1_q, ovf2_q, ovf3_q, ovf_q, sticky_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // S1: s = B - C
    sm_t          s_sum;
    logic [N-1:0] s_fit;
    logic         s_ovf;
    always_comb begin
        s_sum = sm_add(widen(b), sm_neg(widen(c)));
        s_fit = narrow(sm_fit(s_sum, N, SAT_EN));
        s_ovf = sm_ovf(s_sum, N);
    end

    // S2: k = s / sqrt3
    logic [N-1:0] k_mul;
    logic         k_ovf;
    sm_qmul_sat #(.N(N), .Q(Q), .SAT_EN(SAT_EN)) u_mul_k (
        .x(s1_q), .y(INV_SQRT3), .p(k_mul), .ovf(k_ovf)
    );

    // S3: four rotation products
    logic [N-1:0] m1, m2, m3, m4;
    logic         m1_ovf, m2_ovf, m3_ovf, m4_ovf;
    sm_qmul_sat #(.N(N), .Q(Q), .SAT_EN(SAT_EN)) u_mul_p1 (
        .x(alpha2_q), .y(cos2_q), .p(m1), .ovf(m1_ovf)
    );
    sm_qmul_sat #(.N(N), .Q(Q), .SAT_EN(SAT_EN)) u_mul_p2 (
        .x(k2_q), .y(sin2_q), .p(m2), .ovf(m2_ovf)
    );
    sm_qmul_sat #(.N(N), .Q(Q), .SAT_EN(SAT_EN)) u_mul_p3 (
        .x(k2_q), .y(cos2_q), .p(m3), .ovf(m3_ovf)
    );
    sm_qmul_sat #(.N(N), .Q(Q), .SAT_EN(SAT_EN)) u_mul_p4 (
        .x(alpha2_q), .y(sin2_q), .p(m4), .ovf(m4_ovf)
    );

    // S4: d = p1 + p2, q = p3 - p4
    sm_t          d_sum, q_sum;
    logic [N-1:0] d_fit, q_fit;
    logic         dq_ovf;
    always_comb begin
        d_sum  = sm_add(widen(p1_q), widen(p2_q));
        q_sum  = sm_add(widen(p3_q), sm_neg(widen(p4_q)));
        d_fit  = narrow(sm_fit(d_sum, N, SAT_EN));
        q_fit  = narrow(sm_fit(q_sum, N, SAT_EN));
        dq_ovf = sm_ovf(d_sum, N) || sm_ovf(q_sum, N);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            a1_q        <= '0;
            cos1_q      <= '0;
            sin1_q      <= '0;
            s1_q        <= '0;
            ovf1_q      <= 1'b0;
            k2_q        <= '0;
            alpha2_q    <= '0;
            cos2_q      <= '0;
            sin2_q      <= '0;
            ovf2_q      <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            p3_q        <= '0;
            p4_q        <= '0;
            ovf3_q      <= 1'b0;
            d_q         <= '0;
            q_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            v1_q        <= in_valid;
            a1_q        <= a;
            cos1_q      <= cos_q;
            sin1_q      <= sin_q;
            s1_q        <= s_fit;
            ovf1_q      <= s_ovf;
            v2_q        <= v1_q;
            k2_q        <= k_mul;
            alpha2_q    <= a1_q;
            cos2_q      <= cos1_q;
            sin2_q      <= sin1_q;
            ovf2_q      <= ovf1_q || k_ovf;
            v3_q        <= v2_q;
            p1_q        <= m1;
            p2_q        <= m2;
            p3_q        <= m3;
            p4_q        <= m4;
            ovf3_q      <= ovf2_q || m1_ovf || m2_ovf || m3_ovf || m4_ovf;
            out_valid_q <= v3_q;
            d_q         <= d_fit;
            q_q         <= q_fit;
            ovf_q       <= ovf3_q || dq_ovf;
        end
    end

    // A flagged transfer in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (out_valid_q && out_ready && ovf_q) begin
            sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign d          = d_q;
    assign q          = q_q;
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_abc_dq_pipe.sv
// Directed bench for abc_dq_pipe: N=24, Q=12, a saturating and a wrapping instance.
module tb_abc_dq_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] a, b, c, cos_q, sin_q;
    logic        out_ready;
    logic        ovf_clr;
    logic        in_ready, out_valid, out_ovf, ovf_sticky;
    logic [23:0] d, q;
    logic        w_in_ready, w_out_valid, w_out_ovf, w_ovf_sticky;
    logic [23:0] w_d, w_q;

    int n_checks = 0;
    int n_fail   = 0;

    abc_dq_pipe #(.N(24), .Q(12), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .cos_q(cos_q), .sin_q(sin_q),
        .out_valid(out_valid), .out_ready(out_ready), .d(d), .q(q),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    abc_dq_pipe #(.N(24), .Q(12), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .c(c), .cos_q(cos_q), .sin_q(sin_q),
        .out_valid(w_out_valid), .out_ready(out_ready), .d(w_d), .q(w_q),
        .out_ovf(w_out_ovf), .ovf_sticky(w_ovf_sticky), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one sample into an empty pipe and wait (bounded) for its result.
    task automatic send(input logic [23:0] va, input logic [23:0] vb, input logic [23:0] vc,
                        input logic [23:0] vcos, input logic [23:0] vsin, output int lat);
        @(negedge clk);
        a = va; b = vb; c = vc; cos_q = vcos; sin_q = vsin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    function automatic logic [23:0] rnd_sm();
        logic [22:0] m;
        logic        s;
        m = 23'($urandom_range(0, 4096));
        s = 1'($urandom_range(0, 1));
        return {s, m};
    endfunction

    function automatic real sm2r(input logic [23:0] w);
        real v;
        v = real'(w[22:0]);
        return w[23] ? -v : v;
    endfunction

    int          lat;
    int          sent, got;
    logic [23:0] held_d, held_q;
    logic        seen;
    real         ar, br, cr, cr_, sr, md, mq, ed, eq;
    logic [23:0] ra, rb, rc, rcos, rsin;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        a = '0; b = '0; c = '0; cos_q = '0; sin_q = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(d), 32'h0);
        check("rst_q", 32'(q), 32'h0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: pure d-axis, B-C cancels
        send(24'h001000, 24'h800800, 24'h800800, 24'h001000, 24'h000000, lat);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_d", 32'(d), 32'h001000);
        check("t1_q", 32'(q), 32'h000000);
        check("t1_ovf", 32'(out_ovf), 32'd0);

        // 2: (B-C)/sqrt3*sin; q must come out +0
        send(24'h000000, 24'h001000, 24'h801000, 24'h000000, 24'h001000, lat);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_d", 32'(d), 32'h00127A);
        check("t2_q", 32'(q), 32'h000000);
        check("t2_ovf", 32'(out_ovf), 32'd0);

        // 3: overflow, saturating and wrapping instances side by side
        send(24'h7FFFFF, 24'h7FFFFF, 24'hFFFFFF, 24'h001000, 24'h001000, lat);
        check("t3_sticky_before", 32'(ovf_sticky), 32'd0);
        check("t3_d_sat", 32'(d), 32'h7FFFFF);
        check("t3_q_sat", 32'(q), 32'hB61800);
        check("t3_ovf_sat", 32'(out_ovf), 32'd1);
        check("t3_d_wrap", 32'(w_d), 32'h49E7FE);
        check("t3_q_wrap", 32'(w_q), 32'hB61800);
        check("t3_ovf_wrap", 32'(w_out_ovf), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("t3_sticky_set", 32'(ovf_sticky), 32'd1);
        check("t3_sticky_set_wrap", 32'(w_ovf_sticky), 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("t3_sticky_clr", 32'(ovf_sticky), 32'd0);

        // 4: 8-sample stream with out_ready low in cycles 5-7; expect d = A, q = 0
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 8);
            a = 24'(32'h100 * (sent + 1)); b = '0; c = '0;
            cos_q = 24'h001000; sin_q = '0;
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                check("t4_stall_in_ready", 32'(in_ready), 32'd0);
                check("t4_stall_out_valid", 32'(out_valid), 32'd1);
                if (cyc == 5) begin
                    held_d = d;
                    held_q = q;
                end else begin
                    check("t4_hold_d", 32'(d), 32'(held_d));
                    check("t4_hold_q", 32'(q), 32'(held_q));
                end
            end
            if (out_valid && out_ready) begin
                check("t4_stream_d", 32'(d), 32'h100 * (got + 1));
                check("t4_stream_q", 32'(q), 32'h0);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t4_count", 32'(got), 32'd8);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t4_no_dup", 32'(seen), 32'd0);

        // 5: reset with samples in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 24'(32'h200 * (i + 1)); cos_q = 24'h001000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_d", 32'(d), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t5_no_ghost", 32'(seen), 32'd0);
        send(24'h000800, 24'h000000, 24'h000000, 24'h001000, 24'h000000, lat);
        check("t5_new_latency", 32'(lat), 32'd4);
        check("t5_new_d", 32'(d), 32'h000800);

        // 6: random sweep against a real-valued model, tolerance 3 LSB
        for (int i = 0; i < 16; i++) begin
            ra = rnd_sm(); rb = rnd_sm(); rc = rnd_sm(); rcos = rnd_sm(); rsin = rnd_sm();
            send(ra, rb, rc, rcos, rsin, lat);
            ar = sm2r(ra); br = sm2r(rb); cr = sm2r(rc);
            cr_ = sm2r(rcos); sr = sm2r(rsin);
            md = (ar * cr_ + (br - cr) / $sqrt(3.0) * sr) / 4096.0;
            mq = ((br - cr) / $sqrt(3.0) * cr_ - ar * sr) / 4096.0;
            ed = sm2r(d) - md;
            eq = sm2r(q) - mq;
            if (ed < 0.0) ed = -ed;
            if (eq < 0.0) eq = -eq;
            check("t6_valid", 32'(out_valid), 32'd1);
            check("t6_d_tol", 32'(ed <= 3.0), 32'd1);
            check("t6_q_tol", 32'(eq <= 3.0), 32'd1);
            check("t6_ovf", 32'(out_ovf), 32'd0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
